// File: rtl/mul_fixed_acc.sv
// Block accumulator behind the constant-coefficient multiplier: sums up to NUM
// unsigned products, then holds the block sum on a valid/ready output until taken.
module mul_fixed_acc #(
    parameter int WIDTH = 8,
    parameter int NUM   = 4,
    parameter int GUARD = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*WIDTH-1:0]           in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH+GUARD-1:0]     out_sum,
    output logic [$clog2(NUM+1)-1:0]     out_cnt
);

    localparam int SW = 2*WIDTH + GUARD;
    localparam int CW = $clog2(NUM+1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(NUM-1);

    logic [0:0]    r_state;
    logic [SW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_out_sum;
    logic [CW-1:0] r_out_cnt;

    logic          w_accept;
    logic          w_last;
    logic          w_flush_ok;
    logic          w_complete;
    logic [SW-1:0] w_ext;
    logic [SW-1:0] w_sum;
    logic [CW-1:0] w_cnt;

    // in_ready depends on state alone so upstream never sees a path from out_ready.
    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_HOLD);
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;

    assign w_accept   = in_valid && in_ready;
    assign w_last     = w_accept && (r_cnt == CNT_LAST);
    // An empty flush is dropped so no zero-sample block is ever emitted.
    assign w_flush_ok = flush && in_ready && ((r_cnt != '0) || w_accept);
    assign w_complete = w_last || w_flush_ok;
    assign w_ext      = {{GUARD{1'b0}}, in_data};
    assign w_sum      = r_acc + (w_accept ? w_ext : '0);
    assign w_cnt      = r_cnt + CW'(w_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ACC;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_sum <= '0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_complete) begin
                        r_out_sum <= w_sum;
                        r_out_cnt <= w_cnt;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_state   <= ST_HOLD;
                    end else if (w_accept) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_fixed_acc.sv
// Directed-vector bench for mul_fixed_acc (WIDTH=8, NUM=4, GUARD=2).
module tb_mul_fixed_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_sum;
    logic [2:0]  out_cnt;

    int checks = 0;
    int errors = 0;

    mul_fixed_acc #(.WIDTH(8), .NUM(4), .GUARD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Drive one cycle of inputs at a negedge; returns at the next negedge.
    task automatic step(input logic v, input logic [15:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(negedge clk);
    endtask

    task automatic check_block(input string tag, input logic [17:0] sum, input logic [2:0] cnt);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"},   32'(out_sum),   32'(sum));
        chk({tag, ".cnt"},   32'(out_cnt),   32'(cnt));
        chk({tag, ".rdy"},   32'(in_ready),  32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.sum",   32'(out_sum),   32'd0);
        chk("rst.cnt",   32'(out_cnt),   32'd0);
        chk("rst.rdy",   32'(in_ready),  32'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Normal block
        step(1, 185, 0); step(1, 370, 0); step(1, 555, 0);
        chk("t1.no_early", 32'(out_valid), 32'd0);
        step(1, 740, 0);
        check_block("t1", 18'd1850, 3'd4);
        step(0, 0, 0);
        chk("t1.bubble_rdy", 32'(in_ready),  32'd1);
        chk("t1.bubble_vld", 32'(out_valid), 32'd0);
        chk("t1.sum_kept",   32'(out_sum),   32'd1850);

        // Max-value width check
        repeat (4) step(1, 47175, 0);
        check_block("t2", 18'd188700, 3'd4);
        step(0, 0, 0);

        // Flush with partial block, then an empty flush
        step(1, 185, 0); step(1, 370, 0); step(0, 0, 1);
        check_block("t3", 18'd555, 3'd2);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("t3.empty_flush", 32'(out_valid), 32'd0);
        step(0, 0, 0);
        chk("t3.empty_flush2", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        step(1, 185, 0); step(1, 370, 0); step(1, 555, 0); step(1, 740, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 999, 1);
            check_block($sformatf("t4.bp%0d", i), 18'd1850, 3'd4);
        end
        out_ready = 1'b1;
        step(0, 0, 0);
        chk("t4.release", 32'(out_valid), 32'd0);
        step(1, 10, 0); step(1, 20, 0); step(1, 30, 0); step(1, 40, 0);
        check_block("t4.next", 18'd100, 3'd4);
        step(0, 0, 0);

        // Flush concurrent with NUM-th sample
        step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(1, 4, 1);
        check_block("t5", 18'd10, 3'd4);
        step(0, 0, 0);
        chk("t5.no_second0", 32'(out_valid), 32'd0);
        step(0, 0, 0);
        chk("t5.no_second1", 32'(out_valid), 32'd0);

        // Reset while holding a block drops it immediately
        out_ready = 1'b0;
        repeat (4) step(1, 5, 0);
        check_block("t6.pre", 18'd20, 3'd4);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6.hold_rst_vld", 32'(out_valid), 32'd0);
        chk("t6.hold_rst_sum", 32'(out_sum),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset mid-block discards the partial sum
        step(1, 185, 0); step(1, 370, 0); step(1, 555, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t7.rst_vld", 32'(out_valid), 32'd0);
        chk("t7.rst_cnt", 32'(out_cnt),   32'd0);
        chk("t7.rst_rdy", 32'(in_ready),  32'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1, 1, 0);
        check_block("t7.post", 18'd4, 3'd4);
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
